// File: rtl/unidade_controle_jogo.sv
// Control unit for the memory game: Moore FSM sequencing counter, register and comparator.
// Optional play timeout is built only when CONTROLE_TIMEOUT_EN is defined.
module unidade_controle_jogo #(
  parameter int TIMEOUT_CICLOS = 3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       modo,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC4,
  input  logic       fimC16,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  // state | meaning
  // 0x0 INICIAL     | idle after reset, waiting for iniciar
  // 0x1 PREPARA     | clear address counter and jogada register
  // 0x2 ESPERA      | waiting for a play (timeout runs here)
  // 0x4 REGISTRA    | load the play into the register
  // 0x5 COMPARA     | evaluate comparator result
  // 0x6 PROXIMO     | advance address counter
  // 0xA FIM_ACERTOU | game won
  // 0xD FIM_TIMEOUT | game lost by timeout
  // 0xE FIM_ERROU   | game lost by wrong play
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERROU   = 4'hE
  } estado_t;

  estado_t estado, estado_prox;
  logic    modo_r;
  logic    fim_sel;
  logic    timeout;

  assign fim_sel = modo_r ? fimC16 : fimC4;

`ifdef CONTROLE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS);
  logic [TW-1:0] tcount;

  // Counts only while staying in ESPERA, so it leaves at TIMEOUT_CICLOS-1 and never wraps
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcount <= '0;
    end else if (estado == ESPERA && estado_prox == ESPERA) begin
      tcount <= tcount + 1'b1;
    end else begin
      tcount <= '0;
    end
  end

  assign timeout = (tcount == TW'(TIMEOUT_CICLOS - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
      modo_r <= 1'b0;
    end else begin
      estado <= estado_prox;
      if (estado_prox == PREPARA) begin
        modo_r <= modo;
      end
    end
  end

  always_comb begin
    estado_prox = INICIAL;
    case (estado)
      INICIAL:     estado_prox = iniciar ? PREPARA : INICIAL;
      PREPARA:     estado_prox = ESPERA;
      ESPERA: begin
        if (jogada) begin
          estado_prox = REGISTRA;
        end else if (timeout) begin
          estado_prox = FIM_TIMEOUT;
        end else begin
          estado_prox = ESPERA;
        end
      end
      REGISTRA:    estado_prox = COMPARA;
      COMPARA: begin
        if (!igual) begin
          estado_prox = FIM_ERROU;
        end else if (fim_sel) begin
          estado_prox = FIM_ACERTOU;
        end else begin
          estado_prox = PROXIMO;
        end
      end
      PROXIMO:     estado_prox = ESPERA;
      FIM_ACERTOU: estado_prox = iniciar ? PREPARA : FIM_ACERTOU;
      FIM_ERROU:   estado_prox = iniciar ? PREPARA : FIM_ERROU;
      FIM_TIMEOUT: estado_prox = iniciar ? PREPARA : FIM_TIMEOUT;
      default:     estado_prox = INICIAL;
    endcase
  end

  always_comb begin
    zeraC      = 1'b0;
    contaC     = 1'b0;
    zeraR      = 1'b0;
    registraR  = 1'b0;
    acertou    = 1'b0;
    errou      = 1'b0;
    pronto     = 1'b0;
    db_timeout = 1'b0;
    case (estado)
      PREPARA: begin
        zeraC = 1'b1;
        zeraR = 1'b1;
      end
      REGISTRA: registraR = 1'b1;
      PROXIMO:  contaC = 1'b1;
      FIM_ACERTOU: begin
        acertou = 1'b1;
        pronto  = 1'b1;
      end
      FIM_ERROU: begin
        errou  = 1'b1;
        pronto = 1'b1;
      end
      FIM_TIMEOUT: begin
        errou      = 1'b1;
        pronto     = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Randomized self-checking bench for unidade_controle_jogo against a game-level reference model.
// Timeout scenarios follow CONTROLE_TIMEOUT_EN as built.
module tb_unidade_controle_jogo;
  localparam int T = 20;

  logic clock = 1'b0;
  logic reset, iniciar, modo, jogada, igual, fimC4, fimC16;
  logic zeraC, contaC, zeraR, registraR, acertou, errou, pronto, db_timeout;
  logic [3:0] db_estado;
  logic [11:0] obs;

  int errors = 0;
  int checks = 0;

  unidade_controle_jogo #(.TIMEOUT_CICLOS(T)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo), .jogada(jogada),
    .igual(igual), .fimC4(fimC4), .fimC16(fimC16), .zeraC(zeraC), .contaC(contaC),
    .zeraR(zeraR), .registraR(registraR), .acertou(acertou), .errou(errou),
    .pronto(pronto), .db_timeout(db_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  assign obs = {db_estado, zeraC, contaC, zeraR, registraR, acertou, errou, pronto, db_timeout};

  // Expected Moore outputs {state, zeraC, contaC, zeraR, registraR, acertou, errou, pronto, db_timeout}
  function automatic logic [11:0] outs_for(input logic [3:0] st);
    case (st)
      4'h1:    return {st, 8'b1010_0000};
      4'h4:    return {st, 8'b0001_0000};
      4'h6:    return {st, 8'b0100_0000};
      4'hA:    return {st, 8'b0000_1010};
      4'hE:    return {st, 8'b0000_0110};
      4'hD:    return {st, 8'b0000_0111};
      default: return {st, 8'b0000_0000};
    endcase
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; iniciar = 1'b0; modo = 1'b0; jogada = 1'b0;
    igual = 1'b0; fimC4 = 1'b0; fimC16 = 1'b0;
    #23;
    checks++;
    if (obs !== outs_for(4'h0)) begin
      errors++; $display("FAIL reset_held obs=%h exp=%h", obs, outs_for(4'h0));
    end
    tick; reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if (obs !== outs_for(4'h0)) begin
        errors++; $display("FAIL reset_idle cyc=%0d obs=%h exp=%h", i, obs, outs_for(4'h0));
      end
    end
    iniciar = 1'b1; modo = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (obs !== outs_for(i == 0 ? 4'h1 : 4'h2)) begin
        errors++; $display("FAIL start_hold cyc=%0d obs=%h exp=%h", i, obs, outs_for(i == 0 ? 4'h1 : 4'h2));
      end
    end
    iniciar = 1'b0;
  endtask

  // Plays one game: fail_idx < 0 means every play is correct; the game length follows the mode
  task automatic test_game(input bit m, input int fail_idx, input bit do_start);
    int  len;
    bit  ended;
    logic [3:0] exp_st;
    len = m ? 16 : 4;
    ended = 1'b0;
    if (do_start) begin
      iniciar = 1'b1; modo = m;
      tick;
      checks++;
      if (obs !== outs_for(4'h1)) begin
        errors++; $display("FAIL game_prepara obs=%h exp=%h", obs, outs_for(4'h1));
      end
      iniciar = 1'b0;
      tick;
    end
    for (int i = 0; i < len && !ended; i++) begin
      modo = 1'($urandom);
      for (int g = $urandom_range(0, 4); g > 0; g--) begin
        checks++;
        if (obs !== outs_for(4'h2)) begin
          errors++; $display("FAIL game_espera play=%0d obs=%h exp=%h", i, obs, outs_for(4'h2));
        end
        tick;
      end
      igual = (i != fail_idx); fimC4 = (i == 3); fimC16 = (i == 15);
      jogada = 1'b1;
      tick;
      jogada = 1'b0;
      checks++;
      if (obs !== outs_for(4'h4)) begin
        errors++; $display("FAIL game_registra play=%0d obs=%h exp=%h", i, obs, outs_for(4'h4));
      end
      tick;
      checks++;
      if (obs !== outs_for(4'h5)) begin
        errors++; $display("FAIL game_compara play=%0d obs=%h exp=%h", i, obs, outs_for(4'h5));
      end
      tick;
      if (i == fail_idx) begin
        exp_st = 4'hE; ended = 1'b1;
      end else if (i == len - 1) begin
        exp_st = 4'hA; ended = 1'b1;
      end else begin
        exp_st = 4'h6;
      end
      checks++;
      if (obs !== outs_for(exp_st)) begin
        errors++; $display("FAIL game_result play=%0d obs=%h exp=%h", i, obs, outs_for(exp_st));
      end
      if (!ended) tick;
    end
    igual = 1'b0; fimC4 = 1'b0; fimC16 = 1'b0;
    // End state is sticky and ignores stray plays until the next start
    jogada = 1'b1; tick; jogada = 1'b0; tick;
    checks++;
    if (obs !== outs_for(exp_st)) begin
      errors++; $display("FAIL game_end_hold obs=%h exp=%h", obs, outs_for(exp_st));
    end
  endtask

  task automatic test_async_reset;
    iniciar = 1'b1; modo = 1'b0;
    tick; iniciar = 1'b0; tick;
    igual = 1'b1; jogada = 1'b1;
    tick; jogada = 1'b0;
    tick;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs !== outs_for(4'h0)) begin
      errors++; $display("FAIL async_reset obs=%h exp=%h", obs, outs_for(4'h0));
    end
    tick; reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      jogada = 1'b1; tick; jogada = 1'b0; tick;
      checks++;
      if (obs !== outs_for(4'h0)) begin
        errors++; $display("FAIL reset_jogada_ignored i=%0d obs=%h exp=%h", i, obs, outs_for(4'h0));
      end
    end
    igual = 1'b0;
  endtask

  task automatic test_timeout;
`ifdef CONTROLE_TIMEOUT_EN
    iniciar = 1'b1; tick; iniciar = 1'b0; tick;
    for (int i = 1; i < T; i++) tick;
    checks++;
    if (obs !== outs_for(4'h2)) begin
      errors++; $display("FAIL timeout_early obs=%h exp=%h", obs, outs_for(4'h2));
    end
    tick;
    checks++;
    if (obs !== outs_for(4'hD)) begin
      errors++; $display("FAIL timeout_fire obs=%h exp=%h", obs, outs_for(4'hD));
    end
    iniciar = 1'b1; modo = 1'b0; tick; iniciar = 1'b0; tick;
    for (int i = 1; i < T; i++) tick;
    igual = 1'b1; jogada = 1'b1;
    tick; jogada = 1'b0;
    checks++;
    if (obs !== outs_for(4'h4)) begin
      errors++; $display("FAIL timeout_jogada_wins obs=%h exp=%h", obs, outs_for(4'h4));
    end
    tick; tick;
    checks++;
    if (obs !== outs_for(4'h6)) begin
      errors++; $display("FAIL timeout_after_play obs=%h exp=%h", obs, outs_for(4'h6));
    end
    igual = 1'b0;
`else
    iniciar = 1'b1; tick; iniciar = 1'b0; tick;
    repeat (3200) tick;
    checks++;
    if (obs !== outs_for(4'h2)) begin
      errors++; $display("FAIL no_timeout obs=%h exp=%h", obs, outs_for(4'h2));
    end
    // Finish the waiting game with a wrong play so the next start comes from an end state
    jogada = 1'b1; igual = 1'b0; tick; jogada = 1'b0; tick; tick;
    checks++;
    if (obs !== outs_for(4'hE)) begin
      errors++; $display("FAIL no_timeout_play obs=%h exp=%h", obs, outs_for(4'hE));
    end
`endif
  endtask

  task automatic test_random_games;
    for (int k = 0; k < 8; k++) begin
      bit m;
      int len;
      int f;
      m = 1'($urandom);
      len = m ? 16 : 4;
      f = $urandom_range(0, len);
      test_game(m, (f == len) ? -1 : f, 1'b1);
    end
  endtask

  initial begin
    test_reset;
    test_game(1'b0, -1, 1'b0);
    test_game(1'b1, -1, 1'b1);
    test_game(1'b0, 1, 1'b1);
    test_game(1'b1, 5, 1'b1);
    test_async_reset;
    test_timeout;
    test_random_games;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
